zone_avg_stream: RTL and testbench

- Parametrised successor to the ambilight border averager.
- Accumulates exact per-zone RGB sums over a configurable-depth border ring of each video frame.
- At frame end, snapshots the sums and divides them with a sequential divider.
- Streams one averaged colour per zone, in clockwise order, over a valid/ready interface to the LED driver.

---
 rtl/zone_avg_stream_if.sv | 14 +
 rtl/zone_avg_stream.sv | 238 +++++++++++++++++++++++
 tb/tb_zone_avg_stream.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/zone_avg_stream_if.sv
// Output stream from zone_avg_stream to the LED driver: one averaged {R,G,B} colour per zone.
interface zone_avg_stream_if #(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned ZONE_W = 5
);
  logic [3*CH_W-1:0] m_rgb;
  logic [ZONE_W-1:0] m_zone;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_rgb, m_zone, m_valid, m_last, input m_ready);
  modport slave  (input m_rgb, m_zone, m_valid, m_last, output m_ready);
endinterface

// File: rtl/zone_avg_stream.sv
// Border-ring zone colour averager: exact per-zone RGB sums, snapshot at frame end, sequential divide.
// Define ZONE_AVG_ROUND_EN to round quotients to nearest (halves up) instead of truncating.
module zone_avg_stream #(
  parameter int unsigned H_PIX   = 1920,
  parameter int unsigned V_PIX   = 1080,
  parameter int unsigned NUM_H   = 10,
  parameter int unsigned NUM_V   = 5,
  parameter int unsigned BORDER  = 64,
  parameter int unsigned CH_W    = 8,
  parameter int unsigned RB_SWAP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*CH_W-1:0]      pix_rgb,
  input  logic [15:0]            h_cnt,
  input  logic [15:0]            v_cnt,
  input  logic                   p_valid,
  input  logic                   v_sync,
  zone_avg_stream_if.master      m_if,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam int unsigned NZ      = 2 * (NUM_H + NUM_V);
  localparam int unsigned ZW      = H_PIX / NUM_H;
  localparam int unsigned ZH      = (V_PIX - 2 * BORDER) / NUM_V;
  localparam int unsigned CNT_T   = ZW * BORDER;
  localparam int unsigned CNT_S   = BORDER * ZH;
  localparam int unsigned CNT_MAX = (CNT_T > CNT_S) ? CNT_T : CNT_S;
  localparam int unsigned SUM_W   = CH_W + $clog2(CNT_MAX);
  localparam int unsigned DW      = SUM_W + 1;
  localparam int unsigned ZONE_W  = $clog2(NZ);
  localparam int unsigned CNT_W   = $clog2(SUM_W + 1);
  localparam int unsigned CH_MAX  = (1 << CH_W) - 1;

  typedef enum logic [1:0] {StIdle, StDiv, StPresent} state_e;

  state_e               state_q;
  logic                 vs_q;
  logic                 frame_end;
  logic                 busy_q;
  logic [7:0]           overrun_q;
  logic [ZONE_W-1:0]    zone_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DW-1:0]        div_q;
  logic [DW-1:0]        rem_q [3];
  logic [SUM_W-1:0]     quo_q [3];
  logic [3*CH_W-1:0]    rgb_q;
  logic [ZONE_W-1:0]    out_zone_q;
  logic                 valid_q;
  logic                 last_q;

  logic [SUM_W-1:0]     acc_q  [NZ][3];
  logic [SUM_W-1:0]     bank_q [NZ][3];

  logic [CH_W-1:0]      ch [3];
  int unsigned          h_pos, v_pos;
  logic                 pix_hit;
  logic [ZONE_W-1:0]    pix_zone;

  assign frame_end = v_sync & ~vs_q;

  // Internal channel order is always {R,G,B}.
  always_comb begin
    ch[0] = pix_rgb[3*CH_W-1 -: CH_W];
    if (RB_SWAP != 0) begin
      ch[1] = pix_rgb[CH_W-1:0];
      ch[2] = pix_rgb[2*CH_W-1 -: CH_W];
    end else begin
      ch[1] = pix_rgb[2*CH_W-1 -: CH_W];
      ch[2] = pix_rgb[CH_W-1:0];
    end
  end

  always_comb begin
    h_pos    = {16'd0, h_cnt};
    v_pos    = {16'd0, v_cnt};
    pix_hit  = 1'b0;
    pix_zone = '0;
    if (p_valid && !v_sync && h_pos < H_PIX && v_pos < V_PIX) begin
      if (v_pos < BORDER) begin
        if (h_pos < NUM_H * ZW) begin
          pix_hit  = 1'b1;
          pix_zone = ZONE_W'(h_pos / ZW);
        end
      end else if (v_pos >= V_PIX - BORDER) begin
        if (h_pos < NUM_H * ZW) begin
          pix_hit  = 1'b1;
          pix_zone = ZONE_W'(NUM_H + NUM_V + (NUM_H - 1 - h_pos / ZW));
        end
      end else if (v_pos - BORDER < NUM_V * ZH) begin
        if (h_pos >= H_PIX - BORDER) begin
          pix_hit  = 1'b1;
          pix_zone = ZONE_W'(NUM_H + (v_pos - BORDER) / ZH);
        end else if (h_pos < BORDER) begin
          pix_hit  = 1'b1;
          pix_zone = ZONE_W'(2 * NUM_H + NUM_V + (NUM_V - 1 - (v_pos - BORDER) / ZH));
        end
      end
    end
  end

  // Sums are updated in place each cycle, so back-to-back hits on one zone see the latest value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '{default: '0};
      bank_q <= '{default: '0};
    end else if (frame_end) begin
      if (!busy_q) bank_q <= acc_q;
      acc_q <= '{default: '0};
    end else if (pix_hit) begin
      for (int c = 0; c < 3; c++) begin
        acc_q[pix_zone][c] <= acc_q[pix_zone][c] + SUM_W'(ch[c]);
      end
    end
  end

  function automatic logic [DW-1:0] zone_div(input logic [ZONE_W-1:0] z);
    int unsigned zi;
    logic        side;
    zi   = 32'(z);
    side = (zi >= NUM_H && zi < NUM_H + NUM_V) || (zi >= 2 * NUM_H + NUM_V);
    return side ? DW'(CNT_S) : DW'(CNT_T);
  endfunction

  function automatic logic [CH_W-1:0] clamp(input logic [SUM_W-1:0] q);
    if (q > SUM_W'(CH_MAX)) return '1;
    return q[CH_W-1:0];
  endfunction

  logic [ZONE_W-1:0] zone_nxt, ld_zone;
  logic [DW-1:0]     ld_div;
  logic [SUM_W-1:0]  ld_sum [3];
  logic [SUM_W-1:0]  ld_dvd [3];
  logic [DW-1:0]     trial  [3];
  logic [DW-1:0]     rem_d  [3];
  logic [SUM_W-1:0]  quo_d  [3];

  // Zone 0 loads straight from the live sums, since the bank is written on the same edge.
  always_comb begin
    zone_nxt = (zone_q == ZONE_W'(NZ - 1)) ? '0 : zone_q + 1'b1;
    ld_zone  = (state_q == StIdle) ? '0 : zone_nxt;
    ld_div   = zone_div(ld_zone);
    for (int c = 0; c < 3; c++) begin
      ld_sum[c] = (state_q == StIdle) ? acc_q[0][c] : bank_q[ld_zone][c];
`ifdef ZONE_AVG_ROUND_EN
      ld_dvd[c] = ld_sum[c] + ld_div[SUM_W:1];
`else
      ld_dvd[c] = ld_sum[c];
`endif
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      trial[c] = {rem_q[c][SUM_W-1:0], quo_q[c][SUM_W-1]};
      if (trial[c] >= div_q) begin
        rem_d[c] = trial[c] - div_q;
        quo_d[c] = {quo_q[c][SUM_W-2:0], 1'b1};
      end else begin
        rem_d[c] = trial[c];
        quo_d[c] = {quo_q[c][SUM_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vs_q       <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= '0;
      zone_q     <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      rem_q      <= '{default: '0};
      quo_q      <= '{default: '0};
      rgb_q      <= '0;
      out_zone_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      vs_q <= v_sync;
      if (frame_end && busy_q && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          if (frame_end) begin
            busy_q  <= 1'b1;
            zone_q  <= '0;
            cnt_q   <= '0;
            div_q   <= ld_div;
            rem_q   <= '{default: '0};
            quo_q   <= ld_dvd;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SUM_W - 1)) begin
            cnt_q      <= '0;
            rgb_q      <= {clamp(quo_d[0]), clamp(quo_d[1]), clamp(quo_d[2])};
            out_zone_q <= zone_q;
            last_q     <= (zone_q == ZONE_W'(NZ - 1));
            valid_q    <= 1'b1;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          if (m_if.m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (zone_q == ZONE_W'(NZ - 1)) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              zone_q  <= zone_nxt;
              div_q   <= ld_div;
              rem_q   <= '{default: '0};
              quo_q   <= ld_dvd;
              state_q <= StDiv;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_if.m_rgb   = rgb_q;
  assign m_if.m_zone  = out_zone_q;
  assign m_if.m_valid = valid_q;
  assign m_if.m_last  = last_q;
  assign busy         = busy_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_zone_avg_stream.sv
// Directed bench for zone_avg_stream on a 16x12 frame with 8 zones; a second instance uses RB_SWAP=1.
module tb_zone_avg_stream;
  localparam int NZ = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic [15:0] h_cnt = '0;
  logic [15:0] v_cnt = '0;
  logic        p_valid = 1'b0;
  logic        v_sync = 1'b0;
  logic        ready = 1'b1;
  logic        busy0, busy1;
  logic [7:0]  ovr0, ovr1;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp0 [NZ];
  logic [23:0] exp1 [NZ];

  always #5 clk = ~clk;

  zone_avg_stream_if #(.CH_W(8), .ZONE_W(3)) s0 ();
  zone_avg_stream_if #(.CH_W(8), .ZONE_W(3)) s1 ();
  assign s0.m_ready = ready;
  assign s1.m_ready = ready;

  zone_avg_stream #(
    .H_PIX(16), .V_PIX(12), .NUM_H(2), .NUM_V(2), .BORDER(2), .CH_W(8), .RB_SWAP(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_rgb(pix_rgb), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .p_valid(p_valid), .v_sync(v_sync), .m_if(s0.master), .busy(busy0), .overrun_cnt(ovr0)
  );

  zone_avg_stream #(
    .H_PIX(16), .V_PIX(12), .NUM_H(2), .NUM_V(2), .BORDER(2), .CH_W(8), .RB_SWAP(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_rgb(pix_rgb), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .p_valid(p_valid), .v_sync(v_sync), .m_if(s1.master), .busy(busy1), .overrun_cnt(ovr1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] swap(input logic [23:0] c);
    return {c[23:16], c[7:0], c[15:8]};
  endfunction

  task automatic set_uniform(input logic [23:0] c);
    for (int z = 0; z < NZ; z++) begin
      exp0[z] = c;
      exp1[z] = swap(c);
    end
  endtask

  // mode 0: uniform colour; mode 1: R=1 on 15 of zone 0's 16 pixels, everything else black.
  task automatic send_frame(input int mode, input logic [23:0] color);
    for (int v = 0; v < 12; v++) begin
      for (int h = 0; h < 16; h++) begin
        if (mode == 0) pix_rgb = color;
        else pix_rgb = (v < 2 && h < 8 && (h != 0 || v != 0)) ? 24'h010000 : 24'h000000;
        h_cnt   = 16'(h);
        v_cnt   = 16'(v);
        p_valid = 1'b1;
        step();
      end
    end
    p_valid = 1'b0;
    v_sync  = 1'b1;
    repeat (4) step();
    v_sync = 1'b0;
    step();
  endtask

  task automatic wait_valid();
    int t = 0;
    while (s0.m_valid !== 1'b1 && t < 60) begin
      step();
      t++;
    end
    check("wait_valid", 32'(s0.m_valid), 32'd1);
  endtask

  task automatic collect(input int stall_zone);
    for (int i = 0; i < NZ; i++) begin
      if (i == stall_zone) ready = 1'b0;
      wait_valid();
      check("zone0", 32'(s0.m_zone), 32'(i));
      check("rgb0", 32'(s0.m_rgb), 32'(exp0[i]));
      check("last0", 32'(s0.m_last), 32'(i == NZ - 1));
      check("valid1", 32'(s1.m_valid), 32'd1);
      check("zone1", 32'(s1.m_zone), 32'(i));
      check("rgb1", 32'(s1.m_rgb), 32'(exp1[i]));
      if (i == 0) check("busy_stream", 32'(busy0), 32'd1);
      if (i == stall_zone) begin
        for (int k = 0; k < 20; k++) begin
          step();
          check("stall_valid", 32'(s0.m_valid), 32'd1);
          check("stall_zone", 32'(s0.m_zone), 32'(i));
          check("stall_rgb", 32'(s0.m_rgb), 32'(exp0[i]));
        end
        ready = 1'b1;
      end
      step();
      if (i == stall_zone) check("after_stall_valid", 32'(s0.m_valid), 32'd0);
    end
    check("busy0_done", 32'(busy0), 32'd0);
    check("busy1_done", 32'(busy1), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_valid", 32'(s0.m_valid), 32'd0);
    check("rst_last", 32'(s0.m_last), 32'd0);
    check("rst_rgb", 32'(s0.m_rgb), 32'd0);
    check("rst_zone", 32'(s0.m_zone), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ovr", 32'(ovr0), 32'd0);
    rst_n = 1'b1;
    step();

    // Uniform frame
    set_uniform(24'h102030);
    send_frame(0, 24'h102030);
    collect(-1);

    // Truncation vs rounding on zone 0 red: 15/16
    set_uniform(24'h000000);
`ifdef ZONE_AVG_ROUND_EN
    exp0[0] = 24'h010000;
    exp1[0] = 24'h010000;
`endif
    send_frame(1, 24'h000000);
    collect(-1);

    // Channel reorder
    set_uniform(24'h112233);
    send_frame(0, 24'h112233);
    collect(-1);

    // Backpressure on zone 3
    set_uniform(24'h405060);
    send_frame(0, 24'h405060);
    collect(3);

    // Overrun: frame B ends while frame A is stalled on zone 0
    ready = 1'b0;
    set_uniform(24'h010203);
    send_frame(0, 24'h010203);
    wait_valid();
    check("ovr_busy", 32'(busy0), 32'd1);
    send_frame(0, 24'h0A0B0C);
    check("ovr_cnt0", 32'(ovr0), 32'd1);
    check("ovr_cnt1", 32'(ovr1), 32'd1);
    check("ovr_hold_rgb", 32'(s0.m_rgb), 32'h010203);
    check("ovr_hold_zone", 32'(s0.m_zone), 32'd0);
    ready = 1'b1;
    collect(-1);
    set_uniform(24'h204060);
    send_frame(0, 24'h204060);
    collect(-1);
    check("ovr_keep", 32'(ovr0), 32'd1);

    // Reset during zone 2 of the stream
    send_frame(0, 24'h336699);
    begin
      int t = 0;
      while (!(s0.m_valid === 1'b1 && s0.m_zone === 3'd2) && t < 100) begin
        step();
        t++;
      end
    end
    check("reach_zone2", 32'(s0.m_zone), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(s0.m_valid), 32'd0);
    check("mid_rst_rgb", 32'(s0.m_rgb), 32'd0);
    check("mid_rst_zone", 32'(s0.m_zone), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_ovr", 32'(ovr0), 32'd0);
    check("mid_rst_rgb1", 32'(s1.m_rgb), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    set_uniform(24'h123456);
    send_frame(0, 24'h123456);
    collect(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
